// File: rtl/cbf_scan_controller_if.sv
// Bundle of the scan controller's control, ROM, snapshot, estimator and spectrum signals.
// The controller uses the master view; the surrounding system uses the slave view.
interface cbf_scan_controller_if #(
  parameter int IQ_W    = 16,
  parameter int POWER_W = 88,
  parameter int ANGLE_W = 7
);
  localparam int VEC_W = 8 * IQ_W;

  logic               start;
  logic [ANGLE_W-1:0] cfg_first;
  logic [ANGLE_W-1:0] cfg_last;
  logic               busy;
  logic               done;
  logic [ANGLE_W-1:0] steer_addr;
  logic               steer_rd_en;
  logic [VEC_W-1:0]   steer_data;
  logic [VEC_W-1:0]   steer_vec;
  logic [VEC_W-1:0]   s_axis_tdata;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [VEC_W-1:0]   est_tdata;
  logic               est_tvalid;
  logic [POWER_W-1:0] pwr_tdata;
  logic               pwr_tvalid;
  logic [POWER_W+7:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [ANGLE_W-1:0] peak_angle;
  logic [POWER_W-1:0] peak_power;
  logic               peak_valid;

  modport master (
    input  start, cfg_first, cfg_last, steer_data, s_axis_tdata, s_axis_tvalid,
           pwr_tdata, pwr_tvalid, m_axis_tready,
    output busy, done, steer_addr, steer_rd_en, steer_vec, s_axis_tready,
           est_tdata, est_tvalid, m_axis_tdata, m_axis_tvalid,
           peak_angle, peak_power, peak_valid
  );

  modport slave (
    output start, cfg_first, cfg_last, steer_data, s_axis_tdata, s_axis_tvalid,
           pwr_tdata, pwr_tvalid, m_axis_tready,
    input  busy, done, steer_addr, steer_rd_en, steer_vec, s_axis_tready,
           est_tdata, est_tvalid, m_axis_tdata, m_axis_tvalid,
           peak_angle, peak_power, peak_valid
  );
endinterface

// File: rtl/cbf_scan_controller.sv
// Angular scan sequencer for the 4-channel CBF power estimator: loads one steering
// vector per angle, forwards SNAPSHOTS snapshots, captures the power, streams it and tracks the peak.
module cbf_scan_controller #(
  parameter int IQ_W      = 16,
  parameter int SNAPSHOTS = 8,
  parameter int POWER_W   = 88,
  parameter int ANGLE_W   = 7
) (
  input logic                 clk,
  input logic                 rst_n,
  cbf_scan_controller_if.master bus
);
  localparam int VEC_W = 8 * IQ_W;
  localparam int CNT_W = $clog2(SNAPSHOTS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SNAPSHOTS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EMPTY = 3'd1,
    LOAD  = 3'd2,
    LATCH = 3'd3,
    FEED  = 3'd4,
    DRAIN = 3'd5,
    EMIT  = 3'd6,
    NEXT  = 3'd7
  } state_t;

  state_t               state_r;
  logic [ANGLE_W-1:0]   first_r;
  logic [ANGLE_W-1:0]   last_r;
  logic [ANGLE_W-1:0]   angle_r;
  logic [CNT_W-1:0]     snap_cnt_r;
  logic [CNT_W-1:0]     pwr_cnt_r;
  logic                 busy_r;
  logic                 done_r;
  logic                 rd_en_r;
  logic [VEC_W-1:0]     steer_vec_r;
  logic                 tready_r;
  logic [POWER_W+7:0]   m_tdata_r;
  logic                 m_tvalid_r;
  logic [ANGLE_W-1:0]   peak_angle_r;
  logic [POWER_W-1:0]   peak_power_r;
  logic                 peak_valid_r;

  logic                 s_hs_s;
  logic                 snap_last_s;
  logic                 pwr_last_s;
  logic                 better_s;
  logic [7:0]           angle8_s;
  logic [VEC_W-1:0]     est_tdata_s;

  // Handshake, window-complete and peak-compare decodes.
  always_comb begin
    s_hs_s      = bus.s_axis_tvalid & tready_r;
    snap_last_s = s_hs_s & (snap_cnt_r == LAST_CNT);
    angle8_s    = 8'(angle_r);
    // The captured power sits in the low field of the held spectrum beat.
    better_s    = (angle_r == first_r) || (m_tdata_r[POWER_W-1:0] > peak_power_r);
    if ((state_r == FEED) || (state_r == DRAIN)) begin
      pwr_last_s = bus.pwr_tvalid & (pwr_cnt_r == LAST_CNT);
    end else begin
      pwr_last_s = 1'b0;
    end
  end

  // Snapshot pass-through, gated so nothing reaches the estimator outside FEED.
  always_comb begin
    if (tready_r) begin
      est_tdata_s = bus.s_axis_tdata;
    end else begin
      est_tdata_s = {VEC_W{1'b0}};
    end
  end

  // Scan sequencer with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      first_r      <= {ANGLE_W{1'b0}};
      last_r       <= {ANGLE_W{1'b0}};
      angle_r      <= {ANGLE_W{1'b0}};
      snap_cnt_r   <= {CNT_W{1'b0}};
      pwr_cnt_r    <= {CNT_W{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      rd_en_r      <= 1'b0;
      steer_vec_r  <= {VEC_W{1'b0}};
      tready_r     <= 1'b0;
      m_tdata_r    <= {(POWER_W + 8){1'b0}};
      m_tvalid_r   <= 1'b0;
      peak_angle_r <= {ANGLE_W{1'b0}};
      peak_power_r <= {POWER_W{1'b0}};
      peak_valid_r <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      rd_en_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            first_r      <= bus.cfg_first;
            last_r       <= bus.cfg_last;
            busy_r       <= 1'b1;
            peak_valid_r <= 1'b0;
            if (bus.cfg_first > bus.cfg_last) begin
              state_r <= EMPTY;
            end else begin
              angle_r      <= bus.cfg_first;
              peak_angle_r <= {ANGLE_W{1'b0}};
              peak_power_r <= {POWER_W{1'b0}};
              rd_en_r      <= 1'b1;
              state_r      <= LOAD;
            end
          end
        end
        EMPTY: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        LOAD: begin
          state_r <= LATCH;
        end
        LATCH: begin
          steer_vec_r <= bus.steer_data;
          snap_cnt_r  <= {CNT_W{1'b0}};
          pwr_cnt_r   <= {CNT_W{1'b0}};
          tready_r    <= 1'b1;
          state_r     <= FEED;
        end
        FEED, DRAIN: begin
          if (s_hs_s) begin
            snap_cnt_r <= snap_cnt_r + CNT_W'(1);
          end
          if (bus.pwr_tvalid) begin
            pwr_cnt_r <= pwr_cnt_r + CNT_W'(1);
          end
          if (pwr_last_s) begin
            tready_r   <= 1'b0;
            m_tdata_r  <= {angle8_s, bus.pwr_tdata};
            m_tvalid_r <= 1'b1;
            state_r    <= EMIT;
          end else if (snap_last_s) begin
            tready_r <= 1'b0;
            state_r  <= DRAIN;
          end
        end
        EMIT: begin
          if (bus.m_axis_tready) begin
            m_tvalid_r <= 1'b0;
            if (better_s) begin
              peak_angle_r <= angle_r;
              peak_power_r <= m_tdata_r[POWER_W-1:0];
            end
            state_r <= NEXT;
          end
        end
        NEXT: begin
          if (angle_r == last_r) begin
            peak_valid_r <= 1'b1;
            done_r       <= 1'b1;
            busy_r       <= 1'b0;
            state_r      <= IDLE;
          end else begin
            angle_r <= angle_r + ANGLE_W'(1);
            rd_en_r <= 1'b1;
            state_r <= LOAD;
          end
        end
        default: begin
          tready_r   <= 1'b0;
          m_tvalid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy          = busy_r;
  assign bus.done          = done_r;
  assign bus.steer_addr    = angle_r;
  assign bus.steer_rd_en   = rd_en_r;
  assign bus.steer_vec     = steer_vec_r;
  assign bus.s_axis_tready = tready_r;
  assign bus.est_tdata     = est_tdata_s;
  assign bus.est_tvalid    = bus.s_axis_tvalid & tready_r;
  assign bus.m_axis_tdata  = m_tdata_r;
  assign bus.m_axis_tvalid = m_tvalid_r;
  assign bus.peak_angle    = peak_angle_r;
  assign bus.peak_power    = peak_power_r;
  assign bus.peak_valid    = peak_valid_r;
endmodule

// File: tb/tb_cbf_scan_controller.sv
// Directed bench for cbf_scan_controller with a steering ROM, snapshot source,
// moving-sum estimator model and spectrum sink.
module tb_cbf_scan_controller;
  localparam int IQ_W      = 16;
  localparam int SNAPSHOTS = 8;
  localparam int POWER_W   = 88;
  localparam int ANGLE_W   = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cbf_scan_controller_if #(.IQ_W(IQ_W), .POWER_W(POWER_W), .ANGLE_W(ANGLE_W)) bus ();

  cbf_scan_controller #(
    .IQ_W(IQ_W), .SNAPSHOTS(SNAPSHOTS), .POWER_W(POWER_W), .ANGLE_W(ANGLE_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Steering weight peaks at index 22 and falls off linearly.
  function automatic logic [15:0] rom_w(input int a);
    int d;
    d = (a > 22) ? (a - 22) : (22 - a);
    return 16'(64 - d);
  endfunction

  function automatic logic [127:0] rom_word(input int a);
    return {8'(a), 104'd0, rom_w(a)};
  endfunction

  function automatic logic [95:0] exp_beat(input int a, input int snap);
    return {8'(a), 88'(SNAPSHOTS * (snap + int'(rom_w(a))))};
  endfunction

  logic        start_d = 1'b0;
  logic [6:0]  first_d = 7'd0;
  logic [6:0]  last_d  = 7'd0;
  logic [15:0] snap_d  = 16'd0;
  bit          gap_en  = 1'b0;
  bit          lat3    = 1'b0;
  bit          bp_en   = 1'b0;
  int          exp_first = 0;
  int          exp_snap  = 0;
  int          beat_base = 0;

  assign bus.start        = start_d;
  assign bus.cfg_first    = first_d;
  assign bus.cfg_last     = last_d;
  assign bus.s_axis_tdata = {8'hA5, 104'd0, snap_d};

  // Steering ROM: one-cycle read latency.
  logic [127:0] rom_q = 128'd0;
  always @(posedge clk) begin
    if (bus.steer_rd_en) rom_q <= rom_word(int'(bus.steer_addr));
  end
  assign bus.steer_data = rom_q;

  // Snapshot source, optionally valid every other cycle.
  bit tog = 1'b0;
  always @(negedge clk) tog <= ~tog;
  assign bus.s_axis_tvalid = gap_en ? tog : 1'b1;

  // Estimator model: moving sum of (snapshot + weight) over 8 beats, latency 1 or 3.
  logic [31:0] win [8] = '{default: 32'd0};
  logic [31:0] x_s;
  logic [31:0] sum_s;
  logic        e_v [3] = '{default: 1'b0};
  logic [87:0] e_d [3] = '{default: 88'd0};
  assign x_s = 32'(bus.est_tdata[15:0]) + 32'(bus.steer_vec[15:0]);
  always_comb begin
    sum_s = x_s;
    for (int i = 0; i < 7; i++) sum_s = sum_s + win[i];
  end
  always @(posedge clk) begin
    if (bus.est_tvalid) begin
      win[0] <= x_s;
      for (int i = 1; i < 8; i++) win[i] <= win[i-1];
    end
    e_v[0] <= bus.est_tvalid;
    e_d[0] <= 88'(sum_s);
    e_v[1] <= e_v[0];
    e_d[1] <= e_d[0];
    e_v[2] <= e_v[1];
    e_d[2] <= e_d[1];
  end
  assign bus.pwr_tvalid = lat3 ? e_v[2] : e_v[0];
  assign bus.pwr_tdata  = lat3 ? e_d[2] : e_d[0];

  // Spectrum sink: under backpressure each beat waits about 10 cycles.
  int stall_cnt = 0;
  always @(negedge clk) begin
    if (!bus.m_axis_tvalid) stall_cnt <= 0;
    else if (stall_cnt < 10) stall_cnt <= stall_cnt + 1;
  end
  assign bus.m_axis_tready = bp_en ? (stall_cnt >= 10) : 1'b1;

  // Monitor: collects beats, counts pulses and handshakes, checks stalled beats.
  int done_cnt = 0;
  int rd_cnt   = 0;
  int hs_angle = 0;
  logic [95:0] beats [$];
  always @(posedge clk) begin
    if (bus.done) done_cnt <= done_cnt + 1;
    if (bus.steer_rd_en) begin
      rd_cnt   <= rd_cnt + 1;
      hs_angle <= 0;
    end else if (bus.s_axis_tvalid && bus.s_axis_tready) begin
      hs_angle <= hs_angle + 1;
    end
    if (bus.m_axis_tvalid && bus.m_axis_tready) begin
      beats.push_back(bus.m_axis_tdata);
      check_eq("snaps_per_angle", 128'(hs_angle), 128'(SNAPSHOTS));
      check_eq("steer_vec", bus.steer_vec, rom_word(int'(bus.m_axis_tdata[95:88])));
    end else if (bp_en && bus.m_axis_tvalid) begin
      check_eq("stall_tdata", 128'(bus.m_axis_tdata),
               128'(exp_beat(exp_first + (beats.size() - beat_base), exp_snap)));
      check_eq("stall_s_tready", 128'(bus.s_axis_tready), 128'd0);
    end
  end

  task automatic run_scan(input int first, input int last, input int snap,
                          input bit gap, input bit l3, input bit bp);
    int d0;
    int bb;
    int n;
    int pk_a;
    logic [87:0] pk_p;
    logic [87:0] p;
    gap_en    = gap;
    lat3      = l3;
    bp_en     = bp;
    snap_d    = 16'(snap);
    exp_first = first;
    exp_snap  = snap;
    beat_base = beats.size();
    bb        = beat_base;
    d0        = done_cnt;
    first_d   = 7'(first);
    last_d    = 7'(last);
    start_d   = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    check_eq("busy_after_start", 128'(bus.busy), 128'd1);
    check_eq("peak_valid_cleared", 128'(bus.peak_valid), 128'd0);
    for (int c = 0; c < 20000; c++) begin
      if (done_cnt != d0) break;
      @(negedge clk);
    end
    check_eq("done_pulses", 128'(done_cnt - d0), 128'd1);
    check_eq("busy_after_done", 128'(bus.busy), 128'd0);
    n = last - first + 1;
    check_eq("beat_count", 128'(beats.size() - bb), 128'(n));
    for (int i = 0; i < n; i++) begin
      if (bb + i < beats.size()) check_eq("beat", 128'(beats[bb+i]), 128'(exp_beat(first + i, snap)));
    end
    pk_a = first;
    pk_p = 88'(SNAPSHOTS * (snap + int'(rom_w(first))));
    for (int a = first + 1; a <= last; a++) begin
      p = 88'(SNAPSHOTS * (snap + int'(rom_w(a))));
      if (p > pk_p) begin
        pk_a = a;
        pk_p = p;
      end
    end
    check_eq("peak_angle", 128'(bus.peak_angle), 128'(pk_a));
    check_eq("peak_power", 128'(bus.peak_power), 128'(pk_p));
    check_eq("peak_valid", 128'(bus.peak_valid), 128'd1);
  endtask

  int d0;
  int r0;
  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_busy_done", {bus.busy, bus.done}, 128'd0);
    check_eq("rst_steer", {bus.steer_rd_en, bus.steer_addr, bus.steer_vec}, 128'd0);
    check_eq("rst_m_axis", {bus.m_axis_tvalid, bus.m_axis_tdata}, 128'd0);
    check_eq("rst_peak", {bus.peak_valid, bus.peak_angle, bus.peak_power}, 128'd0);
    check_eq("rst_s_tready", {bus.s_axis_tready, bus.est_tvalid}, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_scan(5, 5, 1000, 1'b0, 1'b0, 1'b0);
    run_scan(0, 63, 1000, 1'b0, 1'b0, 1'b0);
    run_scan(20, 24, 300, 1'b0, 1'b0, 1'b1);
    run_scan(30, 33, 77, 1'b1, 1'b1, 1'b0);

    // Empty range: done after one busy cycle, no ROM access.
    bp_en   = 1'b0;
    d0      = done_cnt;
    r0      = rd_cnt;
    first_d = 7'd10;
    last_d  = 7'd3;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    check_eq("empty_busy", {bus.busy, bus.done}, 128'b10);
    @(negedge clk);
    check_eq("empty_done", {bus.busy, bus.done}, 128'b01);
    @(negedge clk);
    check_eq("empty_done_clear", 128'(bus.done), 128'd0);
    check_eq("empty_no_read", 128'(rd_cnt - r0), 128'd0);
    check_eq("empty_pulses", 128'(done_cnt - d0), 128'd1);
    check_eq("empty_peak_valid", 128'(bus.peak_valid), 128'd0);

    // Reset while feeding angle 7.
    gap_en  = 1'b0;
    lat3    = 1'b0;
    snap_d  = 16'd200;
    first_d = 7'd5;
    last_d  = 7'd10;
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (bus.steer_rd_en && (bus.steer_addr == 7'd7)) break;
      @(negedge clk);
    end
    check_eq("reached_angle7", 128'(bus.steer_addr), 128'd7);
    repeat (3) @(negedge clk);
    check_eq("in_feed", 128'(bus.s_axis_tready), 128'd1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_ctrl", {bus.busy, bus.done, bus.s_axis_tready, bus.est_tvalid, bus.steer_rd_en},
             128'd0);
    check_eq("midrst_steer", {bus.steer_addr, bus.steer_vec}, 128'd0);
    check_eq("midrst_m_axis", {bus.m_axis_tvalid, bus.m_axis_tdata}, 128'd0);
    check_eq("midrst_peak", {bus.peak_valid, bus.peak_angle, bus.peak_power}, 128'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst_no_done", 128'(done_cnt - d0), 128'd0);
    run_scan(2, 4, 500, 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
